// File: rtl/cordic_angle_prep.sv
// Angle front-end for the CORDIC rotator: absolute-load or NCO-step input, folded by
// multiples of pi into [-pi/2, pi/2] with a negate flag, over valid/ready handshakes.
module cordic_angle_prep #(
    parameter int PI_MRAD      = 3142,
    parameter int HALF_PI_MRAD = 1571,
    parameter int TWO_PI_MRAD  = 6283
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic signed [15:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_theta,
    output logic               out_flip,
    output logic [3:0]         out_folds,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, FOLD, OUT} state_t;

    localparam logic signed [15:0] PI16       = 16'(PI_MRAD);
    localparam logic signed [15:0] HALF16     = 16'(HALF_PI_MRAD);
    localparam logic signed [15:0] NEG_HALF16 = 16'(-HALF_PI_MRAD);
    localparam logic signed [15:0] STEP_MAX   = 16'(PI_MRAD - 1);
    localparam logic signed [15:0] STEP_MIN   = 16'(-(PI_MRAD - 1));
    localparam logic signed [16:0] SUM_MAX    = 17'(PI_MRAD - 1);
    localparam logic signed [16:0] SUM_MIN    = 17'(-PI_MRAD);
    localparam logic signed [16:0] TWO_PI17   = 17'(TWO_PI_MRAD);

    state_t             state;
    logic signed [15:0] work;
    logic               flip;
    logic [3:0]         folds;
    logic signed [15:0] phase;

    logic               accept;
    logic signed [15:0] step_c;
    logic signed [16:0] sum;
    logic signed [16:0] sum_w;
    logic signed [15:0] start_work;
    logic signed [15:0] next_phase;

    assign in_ready = rst_n && ((state == IDLE) || ((state == OUT) && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        step_c = in_data;
        if (in_data > STEP_MAX) begin
            step_c = STEP_MAX;
        end else if (in_data < STEP_MIN) begin
            step_c = STEP_MIN;
        end
        sum   = {phase[15], phase} + {step_c[15], step_c};
        sum_w = sum;
        if (sum > SUM_MAX) begin
            sum_w = sum - TWO_PI17;
        end else if (sum < SUM_MIN) begin
            sum_w = sum + TWO_PI17;
        end
        start_work = in_mode ? in_data : sum_w[15:0];
    end

    // An odd fold count means the true angle is theta+-pi; keep phase in [-pi, pi).
    always_comb begin
        next_phase = work;
        if (flip) begin
            next_phase = (work < 0) ? work + PI16 : work - PI16;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            flip      <= 1'b0;
            folds     <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            out_theta <= '0;
            out_flip  <= 1'b0;
            out_folds <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work  <= start_work;
                        flip  <= 1'b0;
                        folds <= '0;
                        state <= FOLD;
                    end
                end
                FOLD: begin
                    if (work > HALF16) begin
                        work  <= work - PI16;
                        flip  <= ~flip;
                        folds <= folds + 4'd1;
                    end else if (work < NEG_HALF16) begin
                        work  <= work + PI16;
                        flip  <= ~flip;
                        folds <= folds + 4'd1;
                    end else begin
                        out_theta <= work;
                        out_flip  <= flip;
                        out_folds <= folds;
                        out_valid <= 1'b1;
                        phase     <= next_phase;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            work  <= start_work;
                            flip  <= 1'b0;
                            folds <= '0;
                            state <= FOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_angle_prep.sv
// Directed bench for cordic_angle_prep with hand-computed fold results and latencies.
module tb_cordic_angle_prep;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_mode;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_theta;
    logic               out_flip;
    logic [3:0]         out_folds;
    logic               busy;

    int errors = 0;
    int checks = 0;

    cordic_angle_prep #(
        .PI_MRAD      (3142),
        .HALF_PI_MRAD (1571),
        .TWO_PI_MRAD  (6283)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_theta (out_theta),
        .out_flip  (out_flip),
        .out_folds (out_folds),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, returns edges from accept to out_valid (bounded).
    task automatic run_op(input logic mode, input int data, output int lat);
        int n;
        in_mode  = mode;
        in_data  = 16'(data);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    typedef struct {
        logic mode;
        int   data;
        int   theta;
        int   flip;
        int   folds;
        int   lat;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int lat;
        int any_valid;

        vecs = '{
            '{1'b1,   1571,  1571, 0,  0,  1},
            '{1'b1,   1572, -1570, 1,  1,  2},
            '{1'b1,  -1572,  1570, 1,  1,  2},
            '{1'b1,  -1571, -1571, 0,  0,  1},
            '{1'b1,   3142,     0, 1,  1,  2},
            '{1'b1,  32767,  1347, 0, 10, 11},
            '{1'b1, -32768, -1348, 0, 10, 11},
            '{1'b1,      0,     0, 0,  0,  1},
            '{1'b0,   1000,  1000, 0,  0,  1},
            '{1'b0,   1000, -1142, 1,  1,  2},
            '{1'b0,   1000,  -142, 1,  1,  2},
            '{1'b0,   1000,   859, 1,  1,  2},
            '{1'b0,   5000,   858, 0,  0,  1}
        };

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b1;
        in_data   = 16'sd100;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst in_ready", int'(in_ready), 0);
        check("rst out_valid", int'(out_valid), 0);
        check("rst theta", int'(out_theta), 0);
        check("rst flip", int'(out_flip), 0);
        check("rst folds", int'(out_folds), 0);
        check("rst busy", int'(busy), 0);

        in_valid = 1'b0;
        rst_n    = 1'b1;
        any_valid = 0;
        repeat (4) begin
            tick();
            if (out_valid) any_valid = 1;
        end
        check("post-rst in_ready", int'(in_ready), 1);
        check("post-rst no output", any_valid, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].mode, vecs[i].data, lat);
            check($sformatf("v%0d lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d theta", i), int'(out_theta), vecs[i].theta);
            check($sformatf("v%0d flip", i), int'(out_flip), vecs[i].flip);
            check($sformatf("v%0d folds", i), int'(out_folds), vecs[i].folds);
        end

        // Drain, then hold the consumer off for the next result.
        tick();
        check("drain idle", int'(busy), 0);
        out_ready = 1'b0;
        run_op(1'b1, 4000, lat);
        check("bp lat", lat, 2);
        repeat (5) begin
            tick();
            check("bp valid", int'(out_valid), 1);
            check("bp theta", int'(out_theta), 858);
            check("bp flip", int'(out_flip), 1);
            check("bp folds", int'(out_folds), 1);
            check("bp in_ready", int'(in_ready), 0);
        end
        in_mode   = 1'b1;
        in_data   = 16'sd100;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp handoff valid", int'(out_valid), 0);
        check("bp handoff busy", int'(busy), 1);
        check("bp handoff in_ready", int'(in_ready), 0);
        tick();
        check("bp next valid", int'(out_valid), 1);
        check("bp next theta", int'(out_theta), 100);

        // Abort a long fold with reset in its third FOLD cycle.
        in_mode  = 1'b1;
        in_data  = 16'sd20000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mid busy", int'(busy), 1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid rst busy", int'(busy), 0);
        any_valid = 0;
        repeat (10) begin
            tick();
            if (out_valid) any_valid = 1;
        end
        check("mid rst no output", any_valid, 0);

        run_op(1'b0, 100, lat);
        check("after rst lat", lat, 1);
        check("after rst theta", int'(out_theta), 100);
        check("after rst flip", int'(out_flip), 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
